// File: rtl/ru_pkg.sv
// Shared definitions for the IFM row-window slice: default lane width,
// window state encoding and the vertical stride clamp.
package ru_pkg;

    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } win_state_e;

    // A stride of 0 would never refill the window, and more than K would
    // require discarding rows that were never seen, so clamp to [1, K].
    function automatic int unsigned stride_clamp(input logic [1:0] s, input int unsigned k);
        int unsigned v;
        v = {30'd0, s};
        if (v == 0) v = 1;
        if (v > k) v = k;
        return v;
    endfunction

endpackage

// File: rtl/rf_ifm_row.sv
// One IFM row register: synchronous clear and load enable.
module rf_ifm_row #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rf_ifm_win.sv
// K-row sliding window over an IFM stream with a vertical stride.
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
module rf_ifm_win
    import ru_pkg::*;
#(
    parameter int COL = 8,
    parameter int DW  = DW_DEF,
    parameter int K   = 3
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr,
    input  logic [1:0]                 stride,
    input  logic signed [COL*DW-1:0]   in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic signed [K*COL*DW-1:0] win_data,
    output logic                       win_valid,
    input  logic                       win_ready
);

    localparam int RW = COL * DW;
    localparam int NW = $clog2(K + 1);
    localparam logic [NW-1:0] NEED_K = NW'(K);

    logic [NW-1:0] need_q, need_d;
    logic [1:0]    stride_q;
    logic [NW-1:0] stride_eff;
    win_state_e    state_q, state_d;
    logic          accept, handshake;
    logic [RW-1:0] row_q [K];

    assign stride_eff = NW'(stride_clamp(stride_q, K));
    assign accept     = in_valid & in_ready;
    assign handshake  = win_valid & win_ready;

    // State always mirrors need: EMPTY at K, FULL at 0, FILL in between.
    assign win_valid = (state_q == FULL);
    assign in_ready  = (state_q != FULL);

    always_comb begin
        need_d  = need_q;
        state_d = state_q;
        if (clr) begin
            need_d = NEED_K;
        end else if (handshake) begin
            need_d = stride_eff;
        end else if (accept) begin
            need_d = need_q - 1'b1;
        end
        if (need_d == '0) begin
            state_d = FULL;
        end else if (need_d == NEED_K) begin
            state_d = EMPTY;
        end else begin
            state_d = FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            need_q   <= NEED_K;
            state_q  <= EMPTY;
            stride_q <= 2'd1;
        end else begin
            need_q  <= need_d;
            state_q <= state_d;
            if (clr) begin
                stride_q <= stride;
            end
        end
    end

    // Row i shifts from row i+1; the newest row enters at the top.
    for (genvar i = 0; i < K; i++) begin : g_row
        logic [RW-1:0] d;
        if (i == K - 1) begin : g_top
            assign d = in_data;
        end else begin : g_mid
            assign d = row_q[i+1];
        end
        rf_ifm_row #(.W(RW)) u_row (
            .clk  (clk),
            .rstn (rstn),
            .clr  (clr),
            .load (accept),
            .d    (d),
            .q    (row_q[i])
        );
        assign win_data[i*RW +: RW] = row_q[i];
    end

endmodule

// File: tb/tb_rf_ifm_win.sv
// Directed bench for rf_ifm_win: a K=3 instance for the window flow and a
// K=2 instance for stride clamping and mid-fill reset.
module tb_rf_ifm_win;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // K=3 instance
    logic         rstn, clr, in_valid, win_ready;
    logic [1:0]   stride;
    logic [63:0]  in_data;
    logic         in_ready, win_valid;
    logic [191:0] win_data;

    // K=2 instance
    logic         rstn2, clr2, in_valid2, win_ready2;
    logic [1:0]   stride2;
    logic [63:0]  in_data2;
    logic         in_ready2, win_valid2;
    logic [127:0] win_data2;

    int n_checks = 0;
    int n_errors = 0;

    rf_ifm_win #(.COL(8), .DW(8), .K(3)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .stride    (stride),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_data  (win_data),
        .win_valid (win_valid),
        .win_ready (win_ready)
    );

    rf_ifm_win #(.COL(8), .DW(8), .K(2)) dut2 (
        .clk       (clk),
        .rstn      (rstn2),
        .clr       (clr2),
        .stride    (stride2),
        .in_data   (in_data2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .win_data  (win_data2),
        .win_valid (win_valid2),
        .win_ready (win_ready2)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mkrow(input logic [7:0] b);
        return {8{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse(input logic [1:0] s);
        clr = 1'b1; stride = s; in_valid = 1'b0; win_ready = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1; in_data = mkrow(b);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic clr_pulse2(input logic [1:0] s);
        clr2 = 1'b1; stride2 = s; in_valid2 = 1'b0; win_ready2 = 1'b0;
        tick();
        clr2 = 1'b0;
    endtask

    task automatic push2(input logic [7:0] b);
        in_valid2 = 1'b1; in_data2 = mkrow(b);
        tick();
        in_valid2 = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0; stride = 2'd0; in_data = '0; in_valid = 1'b0; win_ready = 1'b0;
        rstn2 = 1'b0; clr2 = 1'b0; stride2 = 2'd0; in_data2 = '0; in_valid2 = 1'b0; win_ready2 = 1'b0;
        tick();
        tick();
        check("rst_win_data", win_data, '0);
        check("rst_win_valid", win_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        rstn = 1'b1; rstn2 = 1'b1;

        // Three rows after reset fill the window
        push(8'h01);
        check("fill1_data", win_data, {mkrow(8'h01), 128'd0});
        check("fill1_valid", win_valid, 1'b0);
        push(8'h02);
        check("fill2_valid", win_valid, 1'b0);
        push(8'h03);
        check("fill3_valid", win_valid, 1'b1);
        check("fill3_data", win_data, {mkrow(8'h03), mkrow(8'h02), mkrow(8'h01)});
        check("fill3_in_ready", in_ready, 1'b0);

        // stride 1: next window after a single accept
        clr_pulse(2'd1);
        check("s1_clr_data", win_data, '0);
        check("s1_clr_valid", win_valid, 1'b0);
        push(8'h11); push(8'h12); push(8'h13);
        check("s1_w1_valid", win_valid, 1'b1);
        check("s1_w1_data", win_data, {mkrow(8'h13), mkrow(8'h12), mkrow(8'h11)});
        win_ready = 1'b1; in_valid = 1'b1; in_data = mkrow(8'h14);
        tick();
        check("s1_hs_valid", win_valid, 1'b0);
        check("s1_hs_in_ready", in_ready, 1'b1);
        check("s1_hs_no_accept", win_data, {mkrow(8'h13), mkrow(8'h12), mkrow(8'h11)});
        tick();
        win_ready = 1'b0; in_valid = 1'b0;
        check("s1_w2_valid", win_valid, 1'b1);
        check("s1_w2_data", win_data, {mkrow(8'h14), mkrow(8'h13), mkrow(8'h12)});

        // stride 2: need goes back to 2 after the handshake
        clr_pulse(2'd2);
        push(8'h21); push(8'h22); push(8'h23);
        check("s2_w1_valid", win_valid, 1'b1);
        win_ready = 1'b1;
        tick();
        win_ready = 1'b0;
        check("s2_hs_valid", win_valid, 1'b0);
        check("s2_hs_in_ready", in_ready, 1'b1);
        push(8'h24);
        check("s2_one_more_valid", win_valid, 1'b0);
        push(8'h25);
        check("s2_w2_valid", win_valid, 1'b1);
        check("s2_w2_data", win_data, {mkrow(8'h25), mkrow(8'h24), mkrow(8'h23)});

        // Back-pressure: window held while the consumer stalls
        in_valid = 1'b1; in_data = mkrow(8'h26);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_data", win_data, {mkrow(8'h25), mkrow(8'h24), mkrow(8'h23)});
            check("stall_valid", win_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;

        // clr in FILL overrides a simultaneous accept
        clr_pulse(2'd1);
        push(8'h31); push(8'h32);
        check("clrfill_pre_valid", win_valid, 1'b0);
        clr = 1'b1; stride = 2'd1; in_valid = 1'b1; in_data = mkrow(8'h33);
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check("clrfill_data", win_data, '0);
        check("clrfill_valid", win_valid, 1'b0);
        check("clrfill_in_ready", in_ready, 1'b1);
        tick();
        check("clrfill_valid_hold", win_valid, 1'b0);
        push(8'h34); push(8'h35);
        check("clrfill_need3_a", win_valid, 1'b0);
        push(8'h36);
        check("clrfill_need3_b", win_valid, 1'b1);
        check("clrfill_win", win_data, {mkrow(8'h36), mkrow(8'h35), mkrow(8'h34)});

        // K=2, stride 0 clamps to 1
        clr_pulse2(2'd0);
        push2(8'h41); push2(8'h42);
        check("k2_s0_w1_valid", win_valid2, 1'b1);
        check("k2_s0_w1_data", win_data2, {mkrow(8'h42), mkrow(8'h41)});
        win_ready2 = 1'b1;
        tick();
        win_ready2 = 1'b0;
        check("k2_s0_hs_valid", win_valid2, 1'b0);
        push2(8'h43);
        check("k2_s0_w2_valid", win_valid2, 1'b1);
        check("k2_s0_w2_data", win_data2, {mkrow(8'h43), mkrow(8'h42)});

        // K=2, stride 3 clamps to 2
        clr_pulse2(2'd3);
        push2(8'h51); push2(8'h52);
        check("k2_s3_w1_valid", win_valid2, 1'b1);
        win_ready2 = 1'b1;
        tick();
        win_ready2 = 1'b0;
        push2(8'h53);
        check("k2_s3_one_more_valid", win_valid2, 1'b0);
        push2(8'h54);
        check("k2_s3_w2_valid", win_valid2, 1'b1);
        check("k2_s3_w2_data", win_data2, {mkrow(8'h54), mkrow(8'h53)});

        // Reset mid-FILL, with clr and in_valid also asserted
        win_ready2 = 1'b1;
        tick();
        win_ready2 = 1'b0;
        push2(8'h55);
        check("k2_fill_valid", win_valid2, 1'b0);
        rstn2 = 1'b0; clr2 = 1'b1; stride2 = 2'd2; in_valid2 = 1'b1; in_data2 = mkrow(8'h56);
        tick();
        rstn2 = 1'b1; clr2 = 1'b0; in_valid2 = 1'b0;
        check("k2_rst_data", win_data2, '0);
        check("k2_rst_valid", win_valid2, 1'b0);
        check("k2_rst_in_ready", in_ready2, 1'b1);
        push2(8'h57);
        check("k2_rst_need2", win_valid2, 1'b0);
        push2(8'h58);
        check("k2_rst_w_valid", win_valid2, 1'b1);
        win_ready2 = 1'b1;
        tick();
        win_ready2 = 1'b0;
        push2(8'h59);
        check("k2_rst_stride1", win_valid2, 1'b1);
        check("k2_rst_w2_data", win_data2, {mkrow(8'h59), mkrow(8'h58)});

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rf_ifm_win.md
RF_IFM_WIN -- requirements
Module: rf_ifm_win

Interface
REQ-001 Parameter COL, default 8: lanes per IFM row.
REQ-002 Parameter DW, default 8: signed bits per lane.
REQ-003 Parameter K, default 3: rows in the window, K >= 2.
REQ-004 Port clk  in  1: single clock; all state updates on rising edge.
REQ-005 Port rstn  in  1: reset, synchronous, active-low.
REQ-006 Port clr  in  1: synchronous frame-start clear; samples stride.
REQ-007 Port stride  in  2: vertical stride; sampled only when clr=1.
REQ-008 Port in_data  in  COL*DW signed: one IFM row; lane 0 in LSBs.
REQ-009 Port in_valid  in  1: in_data is valid.
REQ-010 Port in_ready  out  1: block accepts a row this cycle.
REQ-011 Port win_data  out  K*COL*DW signed: window; row 0 (oldest) in LSBs.
REQ-012 Port win_valid  out  1: win_data holds a complete window.
REQ-013 Port win_ready  in  1: consumer takes the window.

Function
REQ-014 Row accept = in_valid & in_ready; on accept, row[i] <= row[i+1] for i < K-1, and row[K-1] <= in_data.
REQ-015 Rows shall hold their value in every cycle without accept or clr; no combinational path from in_data to win_data.
REQ-016 win_data shall be the registered concatenation {row[K-1],...,row[0]}; a row accepted in cycle n is visible in win_data in cycle n+1.
REQ-017 Counter need (width clog2(K+1)) = rows still required; win_valid = (need == 0); in_ready = (need != 0).
REQ-018 Each accept shall decrement need by 1; need never underflows.
REQ-019 Window handshake = win_valid & win_ready; on handshake need <= stride_eff.
REQ-020 stride_eff shall be stride_q clamped: 0 -> 1, values > K -> K; stride_q resets to 1.
REQ-021 State encoding: EMPTY (need==K), FILL (0<need<K), FULL (need==0); EMPTY->FILL on first accept, FILL->FULL on the accept reaching need 0, FULL->FILL or EMPTY on handshake per stride_eff.
REQ-022 In FULL, in_ready=0: accept and handshake never occur in the same cycle; one bubble per window is accepted behaviour.
REQ-023 While win_valid=1 and win_ready=0, win_data and win_valid shall stay stable until the handshake.
REQ-024 clr=1 shall override accept and handshake: all rows <= 0, need <= K, stride_q <= stride; win_valid falls the next cycle.
REQ-025 K rows accepted back-to-back after clr shall assert win_valid in the cycle after the K-th accept.

Reset
REQ-026 With rstn=0 at a clock edge: rows=0, need=K, stride_q=1; next-cycle outputs are win_data=0, win_valid=0, in_ready=1.
REQ-027 Reset mid-window shall discard partial rows; rstn has priority over clr.

Structure
REQ-028 Shared package ru_pkg shall hold the DW default, the state enum (EMPTY/FILL/FULL), and the stride clamp function.
REQ-029 One sub-module, rf_ifm_row (COL*DW register with load enable and sync clear), shall be instantiated K times; rf_ifm_win holds the counter, FSM and handshake.

Verification
REQ-030 Reset, then 3 rows 0x01..,0x02..,0x03.. with in_valid=1 -> win_valid high in the cycle after the 3rd accept; win_data = {row3,row2,row1}; in_ready=0.
REQ-031 stride=1 (clr pulse), 4 rows, win_ready=1 -> 2nd window {r4,r3,r2} exactly 1 accept after the 1st handshake.
REQ-032 stride=2, 5 rows -> 2nd window {r5,r4,r3}; need returns to 2 after the 1st handshake.
REQ-033 FULL with win_ready=0 for 10 cycles while in_valid=1 -> win_data stable, no accept, in_ready=0 throughout.
REQ-034 clr asserted in FILL (need=1) together with in_valid=1 -> rows all 0, need=3, no accept; win_valid stays 0.
REQ-035 stride=0 and stride=3 with K=2 -> effective strides 1 and 2; rstn=0 mid-FILL -> reset values of REQ-026.
